// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
// -----------------------------------------------------------------------------
// Sequencer for the shift-add multiplier datapath. It sits between the ALU op
// decoder and the datapath.
//
// On an accepted start it latches both operands and issues a one-cycle dp_load
// to initialise the datapath. It then walks the datapath through one add/shift
// step per operand bit, and raises done for one cycle once the product is stable.
//
// SPLIT_ADD_SHIFT selects how each bit is processed:
//   1 : ADD cycle (conditional add), then SHIFT cycle (shift and count).
//   0 : one ITER cycle does conditional add, shift and count together.
//
// Ports
//   clk           in   1      clock, rising edge
//   rst           in   1      asynchronous, active-high reset
//   start         in   1      multiply request, honoured only in IDLE
//   abort         in   1      cancels an operation in LOAD/ADD/SHIFT/ITER
//   multiplicand  in   WIDTH  operand A, sampled with start
//   multiplier    in   WIDTH  operand B, sampled with start
//   dp_lsb        in   1      datapath product[0]
//   dp_less32     in   1      datapath bit counter is still below 32
//   op_a_q        out  WIDTH  latched multiplicand
//   op_b_q        out  WIDTH  latched multiplier
//   dp_load       out  1      datapath initialise pulse (registered)
//   dp_add        out  1      add-multiplicand strobe (combinational)
//   dp_shr        out  1      shift-right strobe (combinational)
//   dp_incr       out  1      counter-increment strobe (combinational)
//   busy          out  1      high from accept through the DONE cycle (registered)
//   done          out  1      one-cycle result-valid pulse (registered)
// -----------------------------------------------------------------------------
module mult_seq_ctrl #(
    parameter int WIDTH           = 32,
    parameter bit SPLIT_ADD_SHIFT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic             dp_lsb,
    input  logic             dp_less32,
    output logic [WIDTH-1:0] op_a_q,
    output logic [WIDTH-1:0] op_b_q,
    output logic             dp_load,
    output logic             dp_add,
    output logic             dp_shr,
    output logic             dp_incr,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_ITER  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_accept;
    logic             w_add;
    logic             w_shr;
    logic             w_incr;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_dp_load;
    logic             r_busy;
    logic             r_done;

    // A start is only honoured while idle; start requests during an operation are dropped.
    assign w_accept = (r_state == S_IDLE) && start;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. Abort takes priority over the terminal-count check in working states.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_LOAD;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (SPLIT_ADD_SHIFT) begin
                    w_next_state = S_ADD;
                end else begin
                    w_next_state = S_ITER;
                end
            end
            S_ADD: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (dp_less32) begin
                    w_next_state = S_SHIFT;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_ADD;
                end
            end
            S_ITER: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (dp_less32) begin
                    w_next_state = S_ITER;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                // Unused encodings recover to IDLE.
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath strobes. No strobes are issued in the terminal check cycle,
    // so the product stays frozen from that cycle through DONE.
    always_comb begin
        w_add  = 1'b0;
        w_shr  = 1'b0;
        w_incr = 1'b0;
        case (r_state)
            S_ADD: begin
                if (dp_less32) begin
                    w_add = dp_lsb;
                end else begin
                    w_add = 1'b0;
                end
            end
            S_SHIFT: begin
                w_shr  = 1'b1;
                w_incr = 1'b1;
            end
            S_ITER: begin
                if (dp_less32) begin
                    w_add  = dp_lsb;
                    w_shr  = 1'b1;
                    w_incr = 1'b1;
                end else begin
                    w_add  = 1'b0;
                    w_shr  = 1'b0;
                    w_incr = 1'b0;
                end
            end
            default: begin
                w_add  = 1'b0;
                w_shr  = 1'b0;
                w_incr = 1'b0;
            end
        endcase
    end

    // Operand latches. They load only on an accepted start and otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a <= {WIDTH{1'b0}};
            r_op_b <= {WIDTH{1'b0}};
        end else if (w_accept) begin
            r_op_a <= multiplicand;
            r_op_b <= multiplier;
        end else begin
            r_op_a <= r_op_a;
            r_op_b <= r_op_b;
        end
    end

    // Registered status outputs, decoded from the next state so they line up
    // with the state they describe and never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dp_load <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_dp_load <= (w_next_state == S_LOAD);
            r_busy    <= (w_next_state != S_IDLE);
            r_done    <= (w_next_state == S_DONE);
        end
    end

    assign op_a_q  = r_op_a;
    assign op_b_q  = r_op_b;
    assign dp_load = r_dp_load;
    assign dp_add  = w_add;
    assign dp_shr  = w_shr;
    assign dp_incr = w_incr;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl. Two instances are used: u_split (SPLIT_ADD_SHIFT=1)
// and u_fused (SPLIT_ADD_SHIFT=0). Each instance has a small behavioural
// shift-add datapath model closing the loop.
module tb_mult_seq_ctrl;

    logic        clk;
    logic        rst;

    logic        s1_start, s1_abort;
    logic [31:0] s1_a, s1_b, s1_opa, s1_opb;
    logic        s1_lsb, s1_less, s1_load, s1_add, s1_shr, s1_incr, s1_busy, s1_done;

    logic        s0_start, s0_abort;
    logic [31:0] s0_a, s0_b, s0_opa, s0_opb;
    logic        s0_lsb, s0_less, s0_load, s0_add, s0_shr, s0_incr, s0_busy, s0_done;

    logic [64:0] m1_prod, m0_prod;
    logic [6:0]  m1_cnt, m0_cnt;

    int checks;
    int errors;

    mult_seq_ctrl #(.WIDTH(32), .SPLIT_ADD_SHIFT(1'b1)) u_split (
        .clk(clk), .rst(rst), .start(s1_start), .abort(s1_abort),
        .multiplicand(s1_a), .multiplier(s1_b), .dp_lsb(s1_lsb), .dp_less32(s1_less),
        .op_a_q(s1_opa), .op_b_q(s1_opb), .dp_load(s1_load), .dp_add(s1_add),
        .dp_shr(s1_shr), .dp_incr(s1_incr), .busy(s1_busy), .done(s1_done)
    );

    mult_seq_ctrl #(.WIDTH(32), .SPLIT_ADD_SHIFT(1'b0)) u_fused (
        .clk(clk), .rst(rst), .start(s0_start), .abort(s0_abort),
        .multiplicand(s0_a), .multiplier(s0_b), .dp_lsb(s0_lsb), .dp_less32(s0_less),
        .op_a_q(s0_opa), .op_b_q(s0_opb), .dp_load(s0_load), .dp_add(s0_add),
        .dp_shr(s0_shr), .dp_incr(s0_incr), .busy(s0_busy), .done(s0_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One datapath step: the optional add goes into the upper half with a carry bit,
    // and the shift is applied after it.
    function automatic logic [64:0] dp_next(input logic [64:0] p, input logic [31:0] a,
                                            input logic add, input logic shr);
        logic [64:0] t;
        t = p;
        if (add) t[64:32] = {1'b0, t[63:32]} + {1'b0, a};
        if (shr) t = t >> 1;
        return t;
    endfunction

    // Datapath model for the split instance.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1_prod <= 65'd0; m1_cnt <= 7'd0;
        end else if (s1_load) begin
            m1_prod <= {33'd0, s1_opb}; m1_cnt <= 7'd0;
        end else begin
            m1_prod <= dp_next(m1_prod, s1_opa, s1_add, s1_shr);
            if (s1_incr) m1_cnt <= m1_cnt + 7'd1;
        end
    end
    assign s1_lsb  = m1_prod[0];
    assign s1_less = (m1_cnt < 7'd32);

    // Datapath model for the fused instance.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_prod <= 65'd0; m0_cnt <= 7'd0;
        end else if (s0_load) begin
            m0_prod <= {33'd0, s0_opb}; m0_cnt <= 7'd0;
        end else begin
            m0_prod <= dp_next(m0_prod, s0_opa, s0_add, s0_shr);
            if (s0_incr) m0_cnt <= m0_cnt + 7'd1;
        end
    end
    assign s0_lsb  = m0_prod[0];
    assign s0_less = (m0_cnt < 7'd32);

    // Launch a split operation; return at the negedge of cycle c0.
    task automatic kick1(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        s1_start = 1'b1; s1_a = a; s1_b = b;
        @(negedge clk);
        s1_start = 1'b0;
    endtask

    // Launch a fused operation; return at the negedge of cycle c0.
    task automatic kick0(input logic [31:0] a, input logic [31:0] b, input logic with_abort);
        @(negedge clk);
        s0_start = 1'b1; s0_abort = with_abort; s0_a = a; s0_b = b;
        @(negedge clk);
        s0_start = 1'b0; s0_abort = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] outs;
        rst = 1'b1;
        #1;
        outs = {s1_load, s1_add, s1_shr, s1_incr, s1_busy, s1_done, s0_busy, s0_done};
        checks++;
        if (outs !== 8'd0 || s1_opa !== 32'd0 || s1_opb !== 32'd0 || s0_opa !== 32'd0) begin
            errors++; $display("FAIL reset_outputs got %b opa %h opb %h expected all 0", outs, s1_opa, s1_opb);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Mid-operation reset: c6 is a SHIFT cycle with strobes active.
        kick1(32'd3, 32'd5);
        repeat (6) @(negedge clk);
        checks++;
        if (s1_shr !== 1'b1 || s1_busy !== 1'b1) begin
            errors++; $display("FAIL pre_reset_shift got shr %b busy %b expected 1 1", s1_shr, s1_busy);
        end
        #2 rst = 1'b1;
        #1;
        outs = {s1_load, s1_add, s1_shr, s1_incr, s1_busy, s1_done, 2'b00};
        checks++;
        if (outs !== 8'd0 || s1_opa !== 32'd0 || s1_opb !== 32'd0) begin
            errors++; $display("FAIL reset_midcycle got %b opa %h opb %h expected all 0", outs, s1_opa, s1_opb);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (s1_busy !== 1'b0 || s1_shr !== 1'b0 || s1_incr !== 1'b0 || s1_load !== 1'b0) begin
            errors++; $display("FAIL reset_idle got busy %b shr %b incr %b load %b expected 0", s1_busy, s1_shr, s1_incr, s1_load);
        end
    endtask

    task automatic test_split_mult;
        int done_cyc, done_cnt, add_cnt, incr_cnt, bad_busy, bad_load;
        logic [63:0] res;
        done_cyc = -1; done_cnt = 0; add_cnt = 0; incr_cnt = 0; bad_busy = 0; bad_load = 0; res = 64'd0;
        kick1(32'd3, 32'd5);
        for (int c = 0; c < 70; c++) begin
            if (s1_add) add_cnt++;
            if (s1_incr) incr_cnt++;
            if (s1_busy !== ((c <= 66) ? 1'b1 : 1'b0)) bad_busy++;
            if (s1_load !== ((c == 0) ? 1'b1 : 1'b0)) bad_load++;
            if (s1_done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = c; res = m1_prod[63:0]; end
            end
            @(negedge clk);
        end
        checks++; if (done_cyc !== 66) begin errors++; $display("FAIL split_done_cycle got %0d expected 66", done_cyc); end
        checks++; if (res !== 64'd15) begin errors++; $display("FAIL split_result got %h expected %h", res, 64'd15); end
        checks++; if (add_cnt !== 2) begin errors++; $display("FAIL split_add_count got %0d expected 2", add_cnt); end
        checks++; if (incr_cnt !== 32) begin errors++; $display("FAIL split_incr_count got %0d expected 32", incr_cnt); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL split_done_count got %0d expected 1", done_cnt); end
        checks++; if (bad_busy !== 0) begin errors++; $display("FAIL split_busy_window got %0d bad cycles expected 0", bad_busy); end
        checks++; if (bad_load !== 0) begin errors++; $display("FAIL split_load_pulse got %0d bad cycles expected 0", bad_load); end
    endtask

    task automatic test_fused_mult;
        int done_cyc, done_cnt, bad_busy, bad_load;
        logic [63:0] res;
        done_cyc = -1; done_cnt = 0; bad_busy = 0; bad_load = 0; res = 64'd0;
        kick0(32'h0000FFFF, 32'h00010001, 1'b0);
        for (int c = 0; c < 40; c++) begin
            if (s0_busy !== ((c <= 34) ? 1'b1 : 1'b0)) bad_busy++;
            if (s0_load !== ((c == 0) ? 1'b1 : 1'b0)) bad_load++;
            if (s0_done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = c; res = m0_prod[63:0]; end
            end
            @(negedge clk);
        end
        checks++; if (done_cyc !== 34) begin errors++; $display("FAIL fused_done_cycle got %0d expected 34", done_cyc); end
        checks++; if (res !== 64'h00000000FFFFFFFF) begin errors++; $display("FAIL fused_result got %h expected 00000000ffffffff", res); end
        checks++; if (bad_busy !== 0) begin errors++; $display("FAIL fused_busy_window got %0d bad cycles expected 0", bad_busy); end
        checks++; if (bad_load !== 0) begin errors++; $display("FAIL fused_load_pulse got %0d bad cycles expected 0", bad_load); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL fused_done_count got %0d expected 1", done_cnt); end
    endtask

    task automatic test_start_ignored;
        int done_cyc, done_cnt;
        logic [63:0] res;
        done_cyc = -1; done_cnt = 0; res = 64'd0;
        kick1(32'd11, 32'd13);
        for (int c = 0; c < 75; c++) begin
            if (c == 10 || c == 40) begin s1_start = 1'b1; s1_a = 32'd99; s1_b = 32'd77; end
            if (c == 11 || c == 41) s1_start = 1'b0;
            if (s1_done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = c; res = m1_prod[63:0]; end
            end
            @(negedge clk);
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ignore_done_count got %0d expected 1", done_cnt); end
        checks++; if (done_cyc !== 66) begin errors++; $display("FAIL ignore_done_cycle got %0d expected 66", done_cyc); end
        checks++; if (s1_opb !== 32'd13) begin errors++; $display("FAIL ignore_op_b got %0d expected 13", s1_opb); end
        checks++; if (res !== 64'd143) begin errors++; $display("FAIL ignore_result got %0d expected 143", res); end
    endtask

    task automatic test_abort;
        int done_cnt, bad_after, done_cyc;
        logic [63:0] res;
        done_cnt = 0; bad_after = 0; done_cyc = -1; res = 64'd0;
        kick1(32'd3, 32'd5);
        for (int c = 0; c < 80; c++) begin
            if (c == 20) s1_abort = 1'b1;
            if (c == 21) begin
                checks++;
                if (s1_busy !== 1'b0 || s1_add !== 1'b0 || s1_shr !== 1'b0 || s1_incr !== 1'b0) begin
                    errors++; $display("FAIL abort_c21 got busy %b add %b shr %b incr %b expected 0", s1_busy, s1_add, s1_shr, s1_incr);
                end
                s1_abort = 1'b0;
            end
            if (c >= 21 && (s1_add || s1_shr || s1_incr || s1_busy || s1_load)) bad_after++;
            if (s1_done) done_cnt++;
            @(negedge clk);
        end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done got %0d expected 0", done_cnt); end
        checks++; if (bad_after !== 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles expected 0", bad_after); end
        kick1(32'd7, 32'd6);
        for (int c = 0; c < 70; c++) begin
            if (s1_done && done_cyc < 0) begin done_cyc = c; res = m1_prod[63:0]; end
            @(negedge clk);
        end
        checks++; if (done_cyc !== 66) begin errors++; $display("FAIL abort_rerun_cycle got %0d expected 66", done_cyc); end
        checks++; if (res !== 64'd42) begin errors++; $display("FAIL abort_rerun_result got %0d expected 42", res); end
    endtask

    task automatic test_rst_midop;
        int done_cyc;
        logic [63:0] res;
        done_cyc = -1; res = 64'd0;
        kick1(32'd3, 32'd5);
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (s1_busy !== 1'b0 || s1_add !== 1'b0 || s1_shr !== 1'b0 || s1_incr !== 1'b0 || s1_done !== 1'b0) begin
            errors++; $display("FAIL rst_c30 got busy %b add %b shr %b incr %b done %b expected 0", s1_busy, s1_add, s1_shr, s1_incr, s1_done);
        end
        @(negedge clk);
        rst = 1'b0;
        kick1(32'd2, 32'd9);
        for (int c = 0; c < 70; c++) begin
            if (s1_done && done_cyc < 0) begin done_cyc = c; res = m1_prod[63:0]; end
            @(negedge clk);
        end
        checks++; if (done_cyc !== 66) begin errors++; $display("FAIL rst_rerun_cycle got %0d expected 66", done_cyc); end
        checks++; if (res !== 64'd18) begin errors++; $display("FAIL rst_rerun_result got %0d expected 18", res); end
    endtask

    task automatic test_start_abort_idle;
        int done_cyc;
        logic [63:0] res;
        done_cyc = -1; res = 64'd0;
        kick0(32'h00012345, 32'h00000010, 1'b1);
        checks++;
        if (s0_load !== 1'b1 || s0_busy !== 1'b1) begin
            errors++; $display("FAIL start_wins_c0 got load %b busy %b expected 1 1", s0_load, s0_busy);
        end
        for (int c = 0; c < 40; c++) begin
            if (s0_done && done_cyc < 0) begin done_cyc = c; res = m0_prod[63:0]; end
            @(negedge clk);
        end
        checks++; if (done_cyc !== 34) begin errors++; $display("FAIL start_wins_cycle got %0d expected 34", done_cyc); end
        checks++; if (res !== 64'h0000000000123450) begin errors++; $display("FAIL start_wins_result got %h expected 123450", res); end
    endtask

    initial begin
        checks = 0; errors = 0;
        s1_start = 1'b0; s1_abort = 1'b0; s1_a = 32'd0; s1_b = 32'd0;
        s0_start = 1'b0; s0_abort = 1'b0; s0_a = 32'd0; s0_b = 32'd0;
        test_reset();
        test_split_mult();
        test_fused_mult();
        test_start_ignored();
        test_abort();
        test_rst_midop();
        test_start_abort_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
